// File: rtl/rr_arb_mux.sv
// rr_arb_mux: arbitrates 2**N valid/ready channels (round-robin or fixed priority) into one registered output beat.
// Optional ARB_MUX_LOCK_EN adds in_last/out_last and holds the grant on a channel until its last beat.
module rr_arb_mux #(
   parameter int WIDTH = 32,
   parameter int N     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data [2**N],
   input  logic [2**N-1:0]  in_valid,
   output logic [2**N-1:0]  in_ready,
`ifdef ARB_MUX_LOCK_EN
   input  logic [2**N-1:0]  in_last,
   output logic             out_last,
`endif
   input  logic             fixed_prio,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_sel
);

   localparam int NCH = 2**N;

   logic [N-1:0] ptr;
   logic [N-1:0] base;
   logic [N-1:0] idx;
   logic [N-1:0] win;
   logic         found;
   logic         load;
   logic         xfer;
   logic         beat_end;

`ifdef ARB_MUX_LOCK_EN
   logic         locked;
   logic [N-1:0] lock_ch;
`endif

   // The output register can take a new beat when it is empty or being drained this cycle.
   assign load = !out_valid || out_ready;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      base  = fixed_prio ? '0 : ptr;
      for (int k = 0; k < NCH; k++) begin
         idx = base + N'(k);
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
`ifdef ARB_MUX_LOCK_EN
      // A locked channel is the only candidate, even while it is not requesting.
      if (locked) begin
         found = in_valid[lock_ch];
         win   = lock_ch;
      end
`endif
   end

   always_comb begin
      in_ready = '0;
      if (rst_n && load && found) in_ready[win] = 1'b1;
   end

   assign xfer = |(in_valid & in_ready);

`ifdef ARB_MUX_LOCK_EN
   assign beat_end = in_last[win];
`else
   assign beat_end = 1'b1;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the payload register is reset too; it is a single register, not a memory array.
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= in_data[win];
            out_sel  <= win;
            if (!fixed_prio && beat_end) ptr <= win + 1'b1;
         end
      end
   end

`ifdef ARB_MUX_LOCK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         locked   <= 1'b0;
         lock_ch  <= '0;
         out_last <= 1'b0;
      end else if (xfer) begin
         locked   <= !in_last[win];
         lock_ch  <= win;
         out_last <= in_last[win];
      end
   end
`endif

endmodule
